key_press_gen: RTL
==================

Name: key_press_gen

Overview:
- Transmitter-side counterpart of the key_press debouncer. Turns a one-cycle internal request into a physically realistic active-low KEY waveform: bounce, hold, bounce, then an inter-press gap.
- Used for board self-test and auto-demo. A mux ahead of key_press selects this output or the real KEY pin, so TimerController commands can be replayed without touching the board.
- Also used as the stimulus source in key_press benches.

Parameters:
- HOLD_CYCLES, 2500000: cycles key_n is held solidly low per press (50 ms at 50 MHz).
- BOUNCE_CYCLES, 250000: length of each bounce phase, entry and exit.
- BOUNCE_STEP, 12500: cycles between bounce-level updates.
- GAP_CYCLES, 1000000: cycles key_n is held high after each press.
- LFSR_SEED, 16'hACE1: nonzero seed of the bounce LFSR.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high reset.
- press_req  in  1  one-cycle request to start a press burst.
- press_count  in  4  number of presses in the burst; sampled with press_req.
- abort  in  1  one-cycle request to cut the burst short.
- key_n  out  1  emulated KEY pin, active-low; registered.
- busy  out  1  high from the cycle after an accepted press_req until done.
- done  out  1  one-cycle pulse when a burst completes or an abort finishes.

Behaviour:
- Reset values: key_n=1, busy=0, done=0, state=IDLE, remaining=0, LFSR=LFSR_SEED. Reset asserted mid-burst forces key_n high immediately (asynchronous); no done pulse is emitted.
- States: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP. A single phase counter is reloaded on every state entry.
- IDLE:
  - press_req=1 with press_count!=0: latch remaining=press_count, go to BOUNCE_IN next cycle.
  - press_count=0: request is ignored; busy stays 0 and no done pulse.
- BOUNCE_IN, lasting BOUNCE_CYCLES cycles:
  - First cycle: key_n=lfsr[0] after one LFSR step.
  - Every BOUNCE_STEP cycles: LFSR steps (x^16+x^14+x^13+x^11+1) and key_n takes lfsr[0].
  - Last cycle: key_n=0. Then go to HOLD.
- HOLD: key_n=0 for exactly HOLD_CYCLES cycles, then go to BOUNCE_OUT.
- BOUNCE_OUT: same as BOUNCE_IN, except key_n=1 on its last cycle. Then go to GAP.
- GAP: key_n=1 for GAP_CYCLES cycles, then remaining decrements.
  - If remaining is now nonzero: go to BOUNCE_IN.
  - Otherwise: go to IDLE and pulse done for 1 cycle on the IDLE-entry cycle.
- Latency: key_n first reacts one cycle after press_req (registered output). busy rises on that same cycle and falls with done.
- press_req while busy: ignored; it does not queue and does not extend the burst.
- abort while busy: next cycle key_n=1, state=GAP with remaining forced to 1, so done follows after GAP_CYCLES. abort in IDLE is ignored. abort and press_req in the same IDLE cycle: press_req wins.
- The LFSR is not reseeded between bursts; only reset reseeds it.
- Counters are sized with $clog2 of the largest parameter, and all comparisons are unsigned. Every phase parameter must be at least 1; BOUNCE_STEP must be at most BOUNCE_CYCLES.

Optional Feature:
- Macro: KEY_GEN_BOUNCE_EN.
- Defined: bounce phases behave as described above.
- Undefined: BOUNCE_IN and BOUNCE_OUT are skipped entirely, giving clean edges. key_n falls one cycle after press_req and stays low exactly HOLD_CYCLES cycles. The LFSR is not instantiated.

Decomposition:
- Package key_gen_pkg holds:
  - the state enum type (3-bit);
  - the LFSR tap mask constant 16'hB400;
  - the default timing constants at 50 MHz.
- Sub-module lfsr16: Galois LFSR with step enable, seed parameter, and asynchronous reset. Instantiated only under KEY_GEN_BOUNCE_EN.

Test Plan:
Use HOLD_CYCLES=20, BOUNCE_CYCLES=8, BOUNCE_STEP=2, GAP_CYCLES=10 for all scenarios.
- Clean single press, macro undefined: press_req with count=1 at cycle 0 -> key_n=0 on cycles 1..20, high from 21; done pulses at cycle 31; busy high on cycles 1..31.
- Bounced single press, macro defined: count=1 -> key_n level changes only at 2-cycle boundaries on cycles 1..8; key_n=0 at cycle 8; solid low on cycles 9..28; key_n=1 at cycle 36; done at cycle 47. Feeding key_n into key_press gives exactly one key_press pulse.
- Burst: count=3 -> exactly 3 low HOLD windows, separated by GAP; one done; key_press emits 3 pulses and TimerController sees 3 commands.
- Boundaries: count=0 -> no activity, busy=0, no done. press_req during HOLD -> ignored; still one press.
- Abort mid-HOLD at cycle 10, clean mode -> key_n=1 at cycle 11; done at cycle 21; later press_req is accepted normally.
- Reset at cycle 5 of HOLD -> key_n=1 immediately, no done. After release, the same request sequence reproduces the identical bounce pattern because the LFSR is reseeded.

Source files
------------

// File: rtl/key_gen_pkg.sv
// Shared types, default timing and LFSR helpers for the key_press_gen block.
// The default constants assume the 50 MHz board clock.
package key_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_BOUNCE_IN  = 3'd1,
        S_HOLD       = 3'd2,
        S_BOUNCE_OUT = 3'd3,
        S_GAP        = 3'd4
    } key_state_e;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int          DEF_HOLD_CYCLES   = 2500000;
    localparam int          DEF_BOUNCE_CYCLES = 250000;
    localparam int          DEF_BOUNCE_STEP   = 12500;
    localparam int          DEF_GAP_CYCLES    = 1000000;
    localparam logic [15:0] DEF_LFSR_SEED     = 16'hACE1;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        else m = m;
        if (c > m) m = c;
        else m = m;
        if (d > m) m = d;
        else m = m;
        return m;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        if (s[0]) return (s >> 1) ^ LFSR_TAPS;
        else return s >> 1;
    endfunction

endpackage

// File: rtl/key_press_gen_lfsr16.sv
// lfsr16: 16-bit Galois LFSR with step enable; only built when KEY_GEN_BOUNCE_EN is defined.
// o_bit is bit 0 of the value the register takes on the next enabled step.
`ifdef KEY_GEN_BOUNCE_EN
module lfsr16
    import key_gen_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
    input  logic clk,
    input  logic reset,
    input  logic i_step,
    output logic o_bit
);
    logic [15:0] r_state;
    logic [15:0] w_next;

    assign w_next = lfsr_step(r_state);
    assign o_bit  = w_next[0];

    // LFSR state register, reseeded only by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= SEED;
        else if (i_step) r_state <= w_next;
        else r_state <= r_state;
    end

endmodule
`endif

// File: rtl/key_press_gen.sv
// key_press_gen: turns a one-cycle request into a realistic active-low KEY press burst.
// Define KEY_GEN_BOUNCE_EN for LFSR bounce phases around each hold; otherwise edges are clean.
module key_press_gen
    import key_gen_pkg::*;
#(
    parameter int          HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int          BOUNCE_CYCLES = DEF_BOUNCE_CYCLES,
    parameter int          BOUNCE_STEP   = DEF_BOUNCE_STEP,
    parameter int          GAP_CYCLES    = DEF_GAP_CYCLES,
    parameter logic [15:0] LFSR_SEED     = DEF_LFSR_SEED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       press_req,
    input  logic [3:0] press_count,
    input  logic       abort,
    output logic       key_n,
    output logic       busy,
    output logic       done
);
    localparam int CNT_W  = $clog2(max4(HOLD_CYCLES, BOUNCE_CYCLES, GAP_CYCLES, BOUNCE_STEP) + 1);
    localparam int STEP_W = $clog2(BOUNCE_STEP + 1);

`ifdef KEY_GEN_BOUNCE_EN
    localparam key_state_e S_FIRST      = S_BOUNCE_IN;
    localparam key_state_e S_AFTER_HOLD = S_BOUNCE_OUT;
`else
    localparam key_state_e S_FIRST      = S_HOLD;
    localparam key_state_e S_AFTER_HOLD = S_GAP;
`endif

    key_state_e        r_state, w_state_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic [STEP_W-1:0] r_step, w_step_nx;
    logic [3:0]        r_rem, w_rem_nx;
    logic              r_key_n, w_key_nx;
    logic              r_busy, w_busy_nx;
    logic              r_done, w_done_nx;
    logic              w_enter;
    logic              w_lfsr_en;
    logic              w_lfsr_bit;

    // Counter holds (phase length - 1) on entry and counts down to zero.
    function automatic logic [CNT_W-1:0] phase_len_m1(input key_state_e st);
        case (st)
            S_BOUNCE_IN, S_BOUNCE_OUT: return CNT_W'(BOUNCE_CYCLES - 1);
            S_HOLD:                    return CNT_W'(HOLD_CYCLES - 1);
            S_GAP:                     return CNT_W'(GAP_CYCLES - 1);
            default:                   return {CNT_W{1'b0}};
        endcase
    endfunction

    // Phase sequencing, burst bookkeeping and abort override
    always_comb begin
        w_state_nx = r_state;
        w_rem_nx   = r_rem;
        w_cnt_nx   = r_cnt - CNT_W'(1);
        w_done_nx  = 1'b0;
        w_enter    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nx = r_cnt;
                if (press_req && (press_count != 4'd0) && !r_busy) begin
                    w_state_nx = S_FIRST;
                    w_rem_nx   = press_count;
                    w_enter    = 1'b1;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_BOUNCE_IN: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_state_nx = S_HOLD;
                    w_enter    = 1'b1;
                end else begin
                    w_state_nx = S_BOUNCE_IN;
                end
            end
            S_HOLD: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_state_nx = S_AFTER_HOLD;
                    w_enter    = 1'b1;
                end else begin
                    w_state_nx = S_HOLD;
                end
            end
            S_BOUNCE_OUT: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_state_nx = S_GAP;
                    w_enter    = 1'b1;
                end else begin
                    w_state_nx = S_BOUNCE_OUT;
                end
            end
            S_GAP: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_rem_nx = r_rem - 4'd1;
                    w_enter  = 1'b1;
                    if (r_rem != 4'd1) begin
                        w_state_nx = S_FIRST;
                    end else begin
                        w_state_nx = S_IDLE;
                        w_done_nx  = 1'b1;
                    end
                end else begin
                    w_state_nx = S_GAP;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = {CNT_W{1'b0}};
            end
        endcase

        if (abort && (r_state != S_IDLE)) begin
            w_state_nx = S_GAP;
            w_rem_nx   = 4'd1;
            w_done_nx  = 1'b0;
            w_enter    = 1'b1;
        end else begin
            w_state_nx = w_state_nx;
        end

        if (w_enter) w_cnt_nx = phase_len_m1(w_state_nx);
        else w_cnt_nx = w_cnt_nx;

        w_busy_nx = (w_state_nx != S_IDLE) || w_done_nx;
    end

    // Level of key_n for the upcoming cycle, including bounce sampling
    always_comb begin
        w_key_nx  = r_key_n;
        w_step_nx = r_step;
        w_lfsr_en = 1'b0;
        case (w_state_nx)
            S_HOLD: w_key_nx = 1'b0;
            S_BOUNCE_IN, S_BOUNCE_OUT: begin
                if (w_enter || (r_step == STEP_W'(BOUNCE_STEP - 1))) w_step_nx = {STEP_W{1'b0}};
                else w_step_nx = r_step + STEP_W'(1);
                // the final bounce cycle settles to the level of the next phase
                if (w_cnt_nx == {CNT_W{1'b0}}) begin
                    w_key_nx = (w_state_nx == S_BOUNCE_OUT);
                end else if (w_step_nx == {STEP_W{1'b0}}) begin
                    w_lfsr_en = 1'b1;
                    w_key_nx  = w_lfsr_bit;
                end else begin
                    w_key_nx = r_key_n;
                end
            end
            default: w_key_nx = 1'b1;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_step  <= {STEP_W{1'b0}};
            r_rem   <= 4'd0;
            r_key_n <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_step  <= w_step_nx;
            r_rem   <= w_rem_nx;
            r_key_n <= w_key_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
        end
    end

`ifdef KEY_GEN_BOUNCE_EN
    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .i_step (w_lfsr_en),
        .o_bit  (w_lfsr_bit)
    );
`else
    logic        w_unused_lfsr_en;
    logic [15:0] w_unused_seed;
    assign w_lfsr_bit       = 1'b0;
    assign w_unused_lfsr_en = w_lfsr_en;
    assign w_unused_seed    = LFSR_SEED;
`endif

    assign key_n = r_key_n;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
